// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit. It produces a 2*WIDTH-bit result in the HI/LO registers
// after WIDTH shift iterations plus one sign-fix cycle.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic               bz_q, bz_d;
    logic               neg_q, neg_d;
    logic               rsgn_q, rsgn_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               sgn_op;
    logic [WIDTH-1:0]   a_mag, b_mag, addend, quo, rem;
    logic [WIDTH:0]     mul_sum, rem_sh, diff;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        sgn_op  = ~op[0];
        a_mag   = (sgn_op && A[WIDTH-1]) ? -A : A;
        b_mag   = (sgn_op && B[WIDTH-1]) ? -B : B;
        addend  = acc_q[0] ? mcand_q : '0;
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        // Restoring step: shift the next dividend bit into the partial remainder.
        rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff    = rem_sh - {1'b0, mcand_q};
        quo     = acc_q[WIDTH-1:0];
        rem     = acc_q[2*WIDTH-1:WIDTH];
        prod    = neg_q ? -acc_q : acc_q;

        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        a_d     = a_q;
        bz_d    = bz_q;
        neg_d   = neg_q;
        rsgn_d  = rsgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = A;
                    bz_d    = (B == '0);
                    neg_d   = sgn_op & (A[WIDTH-1] ^ B[WIDTH-1]);
                    rsgn_d  = sgn_op & A[WIDTH-1];
                    cnt_d   = '0;
                    acc_d   = op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                    mcand_d = op[1] ? b_mag : a_mag;
                    state_d = S_CALC;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_CALC: begin
                if (op_q[1])
                    acc_d = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                        : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (!op_q[1]) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (bz_q) begin
                    // Divide-by-zero returns the untouched dividend, whatever its sign.
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    hi_d = rsgn_q ? -rem : rem;
                    lo_d = neg_q ? -quo : quo;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            a_q     <= '0;
            bz_q    <= 1'b0;
            neg_q   <= 1'b0;
            rsgn_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            a_q     <= a_d;
            bz_q    <= bz_d;
            neg_q   <= neg_d;
            rsgn_q  <= rsgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != S_IDLE);
    assign done = done_q;
endmodule
